// File: rtl/accum_cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, skip conditions, FSM states
// and ALU operation selects.
package accum_cpu_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_STORE  = 4'h2;
  localparam logic [3:0] OP_ADD    = 4'h3;
  localparam logic [3:0] OP_SUB    = 4'h4;
  localparam logic [3:0] OP_AND    = 4'h5;
  localparam logic [3:0] OP_OR     = 4'h6;
  localparam logic [3:0] OP_NOT    = 4'h7;
  localparam logic [3:0] OP_SKIP   = 4'h8;
  localparam logic [3:0] OP_JUMP   = 4'h9;
  localparam logic [3:0] OP_CLEAR  = 4'hA;
  localparam logic [3:0] OP_LOADI  = 4'hB;
  localparam logic [3:0] OP_MUL    = 4'hC;
  localparam logic [3:0] OP_STOREI = 4'hD;
  localparam logic [3:0] OP_RSVD   = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [1:0] SKIP_NEG   = 2'b00;
  localparam logic [1:0] SKIP_ZERO  = 2'b01;
  localparam logic [1:0] SKIP_POS   = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_W,
    S_DECODE,
    S_RD,
    S_RD_W,
    S_RD2,
    S_RD2_W,
    S_WR,
    S_EXEC,
    S_HALTED
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOT,
    ALU_MUL
  } alu_sel_e;

  function automatic alu_sel_e op_to_alu(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_NOT:  return ALU_NOT;
      OP_MUL:  return ALU_MUL;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/accum_cpu_alu.sv
// Combinational accumulator ALU; the multiplier exists only when ACCUM_CPU_MUL_EN
// is defined. All results wrap modulo 2^DATA_WIDTH.
module accum_cpu_alu
  import accum_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_sel_e              sel,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = b;
    case (sel)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOT: y = ~a;
`ifdef ACCUM_CPU_MUL_EN
      ALU_MUL: y = a * b;
`endif
      default: y = b;
    endcase
  end

endmodule

// File: rtl/accum_cpu_core.sv
// Accumulator CPU core: FSM sequencing fetch/decode/execute against a single-port
// synchronous RAM. Opcode C is MUL when ACCUM_CPU_MUL_EN is defined, else NOP.
module accum_cpu_core
  import accum_cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  busy,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] ac_out,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_oe_q, mem_oe_d;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic [1:0]            skip_cond;
  logic                  skip_take;
  logic [DATA_WIDTH-1:0] alu_y;

  assign opcode    = ir_q[DATA_WIDTH-1 -: 4];
  assign operand   = ir_q[ADDR_WIDTH-1:0];
  assign skip_cond = ir_q[ADDR_WIDTH-1 -: 2];

  always_comb begin
    case (skip_cond)
      SKIP_NEG:  skip_take = ac_q[DATA_WIDTH-1];
      SKIP_ZERO: skip_take = (ac_q == '0);
      SKIP_POS:  skip_take = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
      default:   skip_take = 1'b0;
    endcase
  end

  accum_cpu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a  (ac_q),
    .b  (mbr_q),
    .sel(op_to_alu(opcode)),
    .y  (alu_y)
  );

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    mbr_d       = mbr_q;
    ac_d        = ac_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_oe_d    = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
        end
      end
      S_FETCH:   state_d = S_FETCH_W;
      S_FETCH_W: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_STORE: state_d = S_WR;
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_LOADI, OP_STOREI: state_d = S_RD;
`ifdef ACCUM_CPU_MUL_EN
          OP_MUL:   state_d = S_RD;
`endif
          OP_HALT:  state_d = S_HALTED;
          default:  state_d = S_EXEC;
        endcase
      end
      S_RD: state_d = S_RD_W;
      S_RD_W: begin
        mbr_d = mem_rdata;
        if (opcode == OP_LOADI)       state_d = S_RD2;
        else if (opcode == OP_STOREI) state_d = S_WR;
        else                          state_d = S_EXEC;
      end
      S_RD2:   state_d = S_RD2_W;
      S_RD2_W: begin
        mbr_d   = mem_rdata;
        state_d = S_EXEC;
      end
      S_WR: state_d = S_FETCH;
      S_EXEC: begin
        case (opcode)
          OP_LOAD, OP_LOADI, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_NOT: ac_d = alu_y;
`ifdef ACCUM_CPU_MUL_EN
          OP_MUL:   ac_d = alu_y;
`endif
          OP_SKIP:  if (skip_take) pc_d = pc_q + ADDR_WIDTH'(1);
          OP_JUMP:  pc_d = operand;
          OP_CLEAR: ac_d = '0;
          default:  ;
        endcase
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered, so they are set up from the state being entered.
    case (state_d)
      S_FETCH: begin
        mem_addr_d = pc_d;
        mem_cs_d   = 1'b1;
        mem_oe_d   = 1'b1;
      end
      S_RD: begin
        mem_addr_d = operand;
        mem_cs_d   = 1'b1;
        mem_oe_d   = 1'b1;
      end
      S_RD2: begin
        mem_addr_d = mbr_d[ADDR_WIDTH-1:0];
        mem_cs_d   = 1'b1;
        mem_oe_d   = 1'b1;
      end
      S_WR: begin
        mem_addr_d  = (opcode == OP_STOREI) ? mbr_d[ADDR_WIDTH-1:0] : operand;
        mem_wdata_d = ac_q;
        mem_cs_d    = 1'b1;
        mem_we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      mbr_q       <= '0;
      ac_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      mbr_q       <= mbr_d;
      ac_q        <= ac_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted    = (state_q == S_HALTED);
  assign ac_out    = ac_q;
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_accum_cpu_core.sv
// Self-checking bench for accum_cpu_core: a synchronous RAM model plus an
// instruction-level reference interpreter that predicts AC, PC, memory and cycles.
module tb_accum_cpu_core;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_cs, mem_we, mem_oe;
  logic          busy, halted;
  logic [DW-1:0] ac_out;
  logic [AW-1:0] pc_out;

  logic [DW-1:0] mem     [4096];
  logic [DW-1:0] ref_mem [4096];
  int            wr_count = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  logic [DW-1:0] m_ac;
  logic [AW-1:0] m_pc;
  int            m_writes;
  int            last_cycles;
  int            last_writes;

  always #5 clk = ~clk;

  accum_cpu_core dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_oe   (mem_oe),
    .busy     (busy),
    .halted   (halted),
    .ac_out   (ac_out),
    .pc_out   (pc_out)
  );

  always @(posedge clk) begin
    if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr];
    if (mem_cs && mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_count = wr_count + 1;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  // Instruction-level interpreter: executes ref_mem from 0x100 until HALT.
  task automatic model_run(output int cycles, output bit done);
    logic [DW-1:0] ir;
    logic [AW-1:0] x;
    logic [AW-1:0] ptr;
    logic [1:0]    cond;
    bit            take;
    m_pc = 12'h100;
    m_writes = 0;
    cycles = 0;
    done = 1'b0;
    for (int s = 0; s < 3000 && !done; s++) begin
      ir = ref_mem[m_pc];
      m_pc = m_pc + 12'd1;
      x = ir[11:0];
      case (ir[15:12])
        4'h1: begin m_ac = ref_mem[x];          cycles += 6; end
        4'h2: begin ref_mem[x] = m_ac; m_writes++; cycles += 4; end
        4'h3: begin m_ac = m_ac + ref_mem[x];   cycles += 6; end
        4'h4: begin m_ac = m_ac - ref_mem[x];   cycles += 6; end
        4'h5: begin m_ac = m_ac & ref_mem[x];   cycles += 6; end
        4'h6: begin m_ac = m_ac | ref_mem[x];   cycles += 6; end
        4'h7: begin m_ac = ~m_ac;               cycles += 4; end
        4'h8: begin
          cond = x[11:10];
          take = (cond == 2'd0 && $signed(m_ac) < 0) ||
                 (cond == 2'd1 && m_ac == 16'd0) ||
                 (cond == 2'd2 && $signed(m_ac) > 0);
          if (take) m_pc = m_pc + 12'd1;
          cycles += 4;
        end
        4'h9: begin m_pc = x;    cycles += 4; end
        4'hA: begin m_ac = '0;   cycles += 4; end
        4'hB: begin
          ptr = ref_mem[x][11:0];
          m_ac = ref_mem[ptr];
          cycles += 8;
        end
`ifdef ACCUM_CPU_MUL_EN
        4'hC: begin m_ac = m_ac * ref_mem[x];   cycles += 6; end
`endif
        4'hD: begin
          ptr = ref_mem[x][11:0];
          ref_mem[ptr] = m_ac;
          m_writes++;
          cycles += 6;
        end
        4'hF: begin cycles += 3; done = 1'b1; end
        default: cycles += 4;
      endcase
    end
  endtask

  // Starts the program at 0x100, optionally re-pulses start while busy, and
  // compares the DUT end state with the interpreter's prediction.
  task automatic run_program(input string name, input int budget, input int restart_at);
    int exp_cyc, n, w0, diffs, first_diff;
    bit done;
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
    model_run(exp_cyc, done);
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s/model_bound: interpreter did not reach HALT", name);
    end
    w0 = wr_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || mem_cs !== 1'b1 || mem_oe !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h100) begin
      n_bad++;
      $display("FAIL %s/first_fetch: busy=%b cs=%b oe=%b we=%b addr=%h, want 1 1 1 0 100",
               name, busy, mem_cs, mem_oe, mem_we, mem_addr);
    end
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      start = (n == restart_at);
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    last_cycles = n;
    last_writes = wr_count - w0;
    n_cmp++;
    if (halted !== 1'b1) begin
      n_bad++;
      $display("FAIL %s/timeout: halted=%b after %0d cycles", name, halted, n);
    end
    n_cmp++;
    if (n != exp_cyc) begin
      n_bad++;
      $display("FAIL %s/cycles: got %0d, want %0d", name, n, exp_cyc);
    end
    n_cmp++;
    if (ac_out !== m_ac || pc_out !== m_pc || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s/end_state: ac=%h pc=%h busy=%b, want ac=%h pc=%h busy=0",
               name, ac_out, pc_out, busy, m_ac, m_pc);
    end
    n_cmp++;
    if (last_writes != m_writes) begin
      n_bad++;
      $display("FAIL %s/write_count: got %0d, want %0d", name, last_writes, m_writes);
    end
    diffs = 0;
    first_diff = -1;
    for (int i = 0; i < 4096; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        diffs++;
        if (first_diff < 0) first_diff = i;
      end
    end
    n_cmp++;
    if (diffs != 0) begin
      n_bad++;
      $display("FAIL %s/memory: %0d words differ, first at %h got %h want %h",
               name, diffs, first_diff[11:0], mem[first_diff], ref_mem[first_diff]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (mem_cs !== 1'b0 || mem_we !== 1'b0 || mem_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL reset/strobes: cs=%b we=%b oe=%b, want 0 0 0", mem_cs, mem_we, mem_oe);
    end
    n_cmp++;
    if (mem_addr !== 12'h000 || mem_wdata !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset/bus: addr=%h wdata=%h, want 000 0000", mem_addr, mem_wdata);
    end
    n_cmp++;
    if (busy !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL reset/status: busy=%b halted=%b, want 0 0", busy, halted);
    end
    n_cmp++;
    if (pc_out !== 12'h100 || ac_out !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset/regs: pc=%h ac=%h, want 100 0000", pc_out, ac_out);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || mem_cs !== 1'b0) begin
      n_bad++;
      $display("FAIL reset/rst_beats_start: busy=%b cs=%b, want 0 0", busy, mem_cs);
    end
    m_ac = '0;
  endtask

  task automatic test_mult_program();
    clear_mem();
    mem[12'h100] = 16'h110C;
    mem[12'h101] = 16'h8400;
    mem[12'h102] = 16'h9104;
    mem[12'h103] = 16'hF000;
    mem[12'h104] = 16'h410E;
    mem[12'h105] = 16'h210C;
    mem[12'h106] = 16'h110D;
    mem[12'h107] = 16'h310B;
    mem[12'h108] = 16'h210D;
    mem[12'h109] = 16'h9100;
    mem[12'h10B] = 16'd5;
    mem[12'h10C] = 16'd7;
    mem[12'h10D] = 16'd0;
    mem[12'h10E] = 16'd1;
    run_program("mult", 2000, -1);
    n_cmp++;
    if (mem[12'h10D] !== 16'h0023 || ac_out !== 16'h0000 || pc_out !== 12'h104) begin
      n_bad++;
      $display("FAIL mult/product: M[10D]=%h ac=%h pc=%h, want 0023 0000 104",
               mem[12'h10D], ac_out, pc_out);
    end
  endtask

  task automatic test_loadi_storei();
    clear_mem();
    mem[12'h100] = 16'hB120;
    mem[12'h101] = 16'hD121;
    mem[12'h102] = 16'hF000;
    mem[12'h120] = 16'h0130;
    mem[12'h130] = 16'hBEEF;
    mem[12'h121] = 16'h0140;
    run_program("indirect", 200, -1);
    n_cmp++;
    if (mem[12'h140] !== 16'hBEEF || ac_out !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL indirect/values: M[140]=%h ac=%h, want BEEF BEEF", mem[12'h140], ac_out);
    end
    n_cmp++;
    if (last_writes != 1 || last_cycles != 17) begin
      n_bad++;
      $display("FAIL indirect/timing: writes=%0d cycles=%0d, want 1 17", last_writes, last_cycles);
    end
  endtask

  task automatic test_skipcond();
    logic [15:0] vals  [6] = '{16'h8000, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF};
    logic [1:0]  conds [6] = '{2'b00,    2'b01,    2'b10,    2'b11,    2'b00,    2'b10};
    bit          skips [6] = '{1'b1,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0};
    logic [11:0] want_pc;
    for (int k = 0; k < 6; k++) begin
      clear_mem();
      mem[12'h100] = 16'h1150;
      mem[12'h101] = {4'h8, conds[k], 10'h000};
      mem[12'h102] = 16'hF000;
      mem[12'h103] = 16'hF000;
      mem[12'h150] = vals[k];
      run_program("skip", 200, -1);
      want_pc = skips[k] ? 12'h104 : 12'h103;
      n_cmp++;
      if (pc_out !== want_pc) begin
        n_bad++;
        $display("FAIL skip/case%0d: ac=%h cond=%b pc=%h, want pc=%h", k, vals[k], conds[k], pc_out, want_pc);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want_mul;
    clear_mem();
    mem[12'h100] = 16'h1150;
    mem[12'h101] = 16'h3151;
    mem[12'h102] = 16'hF000;
    mem[12'h150] = 16'hFFFF;
    mem[12'h151] = 16'h0002;
    run_program("add_wrap", 200, -1);
    n_cmp++;
    if (ac_out !== 16'h0001) begin
      n_bad++;
      $display("FAIL add_wrap/ac: got %h, want 0001", ac_out);
    end

    clear_mem();
    mem[12'h100] = 16'h9FFF;
    mem[12'hFFF] = 16'h0000;
    mem[12'h000] = 16'hF000;
    run_program("pc_wrap", 200, -1);
    n_cmp++;
    if (pc_out !== 12'h001) begin
      n_bad++;
      $display("FAIL pc_wrap/pc: got %h, want 001", pc_out);
    end

    clear_mem();
    mem[12'h100] = 16'h1150;
    mem[12'h101] = 16'hC150;
    mem[12'h102] = 16'hF000;
    mem[12'h150] = 16'h0100;
`ifdef ACCUM_CPU_MUL_EN
    want_mul = 16'h0000;
`else
    want_mul = 16'h0100;
`endif
    run_program("mul", 200, -1);
    n_cmp++;
    if (ac_out !== want_mul) begin
      n_bad++;
      $display("FAIL mul/ac: got %h, want %h", ac_out, want_mul);
    end
  endtask

  task automatic test_reset_mid_store();
    int n, w0;
    clear_mem();
    mem[12'h100] = 16'h1150;
    mem[12'h101] = 16'h2160;
    mem[12'h102] = 16'hF000;
    mem[12'h150] = 16'h1234;
    w0 = wr_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(mem_cs === 1'b1 && mem_oe === 1'b1 && mem_addr === 12'h101) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (n >= 50) begin
      n_bad++;
      $display("FAIL rst_store/wait_fetch: STORE fetch not seen within %0d cycles", n);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || mem_cs !== 1'b0 || ac_out !== 16'h0000 || pc_out !== 12'h100) begin
      n_bad++;
      $display("FAIL rst_store/state: busy=%b cs=%b ac=%h pc=%h, want 0 0 0000 100",
               busy, mem_cs, ac_out, pc_out);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_count != w0 || mem[12'h160] !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_store/no_write: writes=%0d M[160]=%h, want 0 0000", wr_count - w0, mem[12'h160]);
    end
    m_ac = '0;
  endtask

  task automatic test_start_busy();
    clear_mem();
    for (int i = 0; i < 10; i++) mem[12'h100 + i] = 16'h0000;
    mem[12'h10A] = 16'hF000;
    run_program("start_busy", 300, 5);
    n_cmp++;
    if (last_cycles != 43 || pc_out !== 12'h10B) begin
      n_bad++;
      $display("FAIL start_busy/ignored: cycles=%0d pc=%h, want 43 10B", last_cycles, pc_out);
    end
  endtask

  // Random straight-line programs; AC carries over between runs, so each restart
  // from HALTED also checks that AC is retained.
  task automatic test_random();
    logic [3:0]  op;
    logic [11:0] x;
    for (int p = 0; p < 25; p++) begin
      clear_mem();
      for (int i = 0; i < 64; i++) begin
        case ($urandom_range(0, 4))
          0:       mem[12'h200 + i] = 16'h0000;
          1:       mem[12'h200 + i] = 16'h8000;
          default: mem[12'h200 + i] = 16'($urandom);
        endcase
      end
      for (int i = 0; i < 16; i++) mem[12'h240 + i] = 16'h0200 + 16'($urandom_range(0, 63));
      for (int i = 0; i < 20; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF || op == 4'h9) op = 4'h0;
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hC: x = 12'h200 + 12'($urandom_range(0, 63));
          4'hB, 4'hD: x = 12'h240 + 12'($urandom_range(0, 15));
          default:    x = 12'($urandom);
        endcase
        mem[12'h100 + i] = {op, x};
      end
      mem[12'h114] = 16'hF000;
      mem[12'h115] = 16'hF000;
      run_program("random", 400, -1);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    m_ac = '0;
    test_reset();
    test_mult_program();
    test_loadi_storei();
    test_skipcond();
    test_wrap();
    test_reset_mid_store();
    test_start_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/accum_cpu_core.md
Name: accum_cpu_core

Overview:
- Synthesizable, parametrised accumulator CPU core; replaces bench-driven fetch/decode/execute sequencing with an RTL FSM.
- Drives the existing single-port synchronous RAM (cs/we/oe, shared address, 1-cycle read latency) and holds PC, IR, MBR, AC internally.
- Adds defined reset, start/halt handshake, signed skip conditions, indirect load/store and wrap-around arithmetic at any width.

Parameters:
- ADDR_WIDTH, 12, memory address width; PC width.
- DATA_WIDTH, 16, word/AC/IR width; must be ≥ ADDR_WIDTH+4.
- RESET_PC, 'h100, PC value after reset and on start.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle pulse; starts execution at RESET_PC from IDLE or HALTED.
- mem_addr  out  ADDR_WIDTH  RAM address, registered.
- mem_wdata  out  DATA_WIDTH  RAM write data, registered.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read request.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_oe  out  1  RAM output enable (read).
- busy  out  1  high while not IDLE/HALTED.
- halted  out  1  high in HALTED.
- ac_out  out  DATA_WIDTH  accumulator value.
- pc_out  out  ADDR_WIDTH  program counter value.

Behaviour:
- Reset: state=IDLE, PC=RESET_PC, IR=MBR=AC=0, mem_addr=0, mem_wdata=0, mem_cs=mem_we=mem_oe=0, busy=0, halted=0. Reset mid-instruction aborts the instruction with no further memory write.
- Instruction: opcode=IR[DATA_WIDTH-1 -: 4], operand X=IR[ADDR_WIDTH-1:0].
- Read protocol: state issuing a read drives mem_addr, cs=1, oe=1, we=0; mem_rdata sampled in the next state. Write: one cycle with cs=1, we=1, oe=0, mem_addr/mem_wdata valid. Outside accesses cs=we=oe=0.
- States: IDLE → (start) FETCH → FETCH_W (IR<=rdata, PC<=PC+1 mod 2^ADDR_WIDTH) → DECODE → opcode path → FETCH. HALTED → (start) FETCH with PC=RESET_PC, AC preserved.
- Opcode paths (cycles after DECODE):
  - 0 NOP: back to FETCH.
  - 1 LOAD: RD X → RD_W (MBR<=rdata) → EXEC (AC<=MBR).
  - 2 STORE: WR (addr=X, wdata=AC).
  - 3 ADD / 4 SUB / 5 AND / 6 OR: RD X → RD_W → EXEC (AC<=AC op MBR, modulo 2^DATA_WIDTH).
  - 7 NOT: EXEC AC<=~AC; no memory access.
  - 8 SKIPCOND on IR[ADDR_WIDTH-1 -: 2], AC signed: 00 AC<0, 01 AC==0, 10 AC>0, 11 never; on true PC<=PC+1.
  - 9 JUMP: PC<=X.
  - A CLEAR: AC<=0.
  - B LOADI: RD X → RD_W (MBR<=rdata) → RD MBR[ADDR_WIDTH-1:0] → RD_W → EXEC (AC<=MBR).
  - D STOREI: RD X → RD_W → WR (addr=MBR[ADDR_WIDTH-1:0], wdata=AC).
  - C MUL: see Optional Feature.
  - E: reserved, treated as NOP.
  - F HALT: HALTED, halted=1, busy=0.
- Timing: NOP/JUMP/CLEAR/SKIP/NOT = 4 cycles; STORE = 4; LOAD/ALU = 6; STOREI = 6; LOADI = 8.
- PC wraps modulo 2^ADDR_WIDTH (PC at all-ones + 1 → 0). start while busy is ignored. start and rst in the same cycle: rst wins.

Optional Feature:
- Macro ACCUM_CPU_MUL_EN.
- Defined: opcode C = MUL. Uses the LOAD/ALU path with AC<=low DATA_WIDTH bits of AC*MBR; 6 cycles.
- Undefined: opcode C = NOP (4 cycles); no multiplier synthesized.

Decomposition:
- Package accum_cpu_pkg: 4-bit opcode localparams (OP_NOP..OP_HALT), skip condition codes, FSM state encoding, ALU select codes.
- One sub-module: accum_cpu_alu, combinational, parameter DATA_WIDTH; inputs a, b, sel; output y. Implements ADD/SUB/AND/OR/NOT/PASS and MUL under ACCUM_CPU_MUL_EN.
- FSM and register file stay in accum_cpu_core.

Test Plan:
- Reset: rst high 2 cycles → all outputs at reset values, PC=0x100, mem_cs=0.
- Multiply-by-addition program preloaded at 0x100 (mult 0x10B=5, 0x10C=7, loop with SKIPCOND/JUMP, HALT) → start pulse → halted=1, M[0x10D]=0x0023, ac_out as expected.
- LOADI/STOREI: M[0x120]=0x0130, M[0x130]=0xBEEF → LOADI 0x120 → AC=0xBEEF in 8 cycles. STOREI 0x121 with M[0x121]=0x0140 → M[0x140]=0xBEEF, single we pulse.
- SKIPCOND: AC=0x8000 with cond 00 → PC skips one. AC=0 with cond 01 → skip. AC=1 with cond 10 → skip. cond 11 → no skip.
- Wrap: ADD with AC=0xFFFF, M=2 → AC=0x0001. JUMP 0xFFF then NOP → PC=0x000. With ACCUM_CPU_MUL_EN: 0x0100*0x0100 → AC=0x0000.
- Reset mid-STORE (rst asserted in DECODE) → no write occurs. start during busy → ignored. start after HALT → restart at 0x100 with AC retained.
